// File: rtl/control_fsm.sv
// Multi-cycle instruction control FSM: sequences IF/ID/EX/MEM/WB, decodes the
// RV32 subset into datapath controls and counts retired instructions.
module control_fsm #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr,
  input  logic                 Zero,
  input  logic                 mem_ready,
  output logic                 PCSrc,
  output logic                 ALUSrc,
  output logic                 RegWrite,
  output logic                 MemToReg,
  output logic                 loadPC,
  output logic [3:0]           ALUCtrl,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] retired
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  state_t     cur;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5;
  logic       is_r, is_i, is_lw, is_sw, is_beq;
  logic       unused_instr_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign f7b5   = instr[30];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  assign is_r   = (opcode == OP_R);
  assign is_i   = (opcode == OP_I);
  assign is_lw  = (opcode == OP_LW);
  assign is_sw  = (opcode == OP_SW);
  assign is_beq = (opcode == OP_BEQ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur     <= S_IF;
      retired <= '0;
    end else begin
      case (cur)
        S_IF:  cur <= S_ID;
        S_ID:  cur <= S_EX;
        S_EX:  cur <= S_MEM;
        // Only memory ops wait on mem_ready; everything else passes through MEM.
        S_MEM: if (!((is_lw || is_sw) && !mem_ready)) cur <= S_WB;
        S_WB: begin
          cur     <= S_IF;
          retired <= retired + CNT_WIDTH'(1);
        end
        default: cur <= S_IF;
      endcase
    end
  end

  assign state = cur;

  always_comb begin
    ALUCtrl = ALU_ADD;
    if (is_r || is_i) begin
      case (funct3)
        3'b000:  ALUCtrl = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
        3'b001:  ALUCtrl = ALU_SLL;
        3'b010:  ALUCtrl = ALU_SLT;
        3'b100:  ALUCtrl = ALU_XOR;
        3'b101:  ALUCtrl = f7b5 ? ALU_SRA : ALU_SRL;
        3'b110:  ALUCtrl = ALU_OR;
        3'b111:  ALUCtrl = ALU_AND;
        default: ALUCtrl = ALU_ADD;
      endcase
    end else if (is_beq) begin
      ALUCtrl = ALU_SUB;
    end
  end

  assign ALUSrc   = is_i || is_lw || is_sw;
  assign MemToReg = is_lw;
  assign MemRead  = (cur == S_MEM) && is_lw;
  assign MemWrite = (cur == S_MEM) && is_sw;
  assign RegWrite = (cur == S_WB) && (is_r || is_i || is_lw);
  assign loadPC   = (cur == S_WB);
  assign PCSrc    = (cur == S_WB) && is_beq && Zero;

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: directed RV32 instructions plus random instruction
// streams, each checked cycle by cycle against a trace-level reference model.
module tb_control_fsm;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   instr;
  logic          Zero;
  logic          mem_ready;
  logic          PCSrc, ALUSrc, RegWrite, MemToReg, loadPC;
  logic [3:0]    ALUCtrl;
  logic          MemRead, MemWrite;
  logic [2:0]    state;
  logic [CW-1:0] retired;
  logic [11:0]   ctrl_vec;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_ret = 0;

  control_fsm #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .instr(instr), .Zero(Zero), .mem_ready(mem_ready),
    .PCSrc(PCSrc), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemToReg(MemToReg),
    .loadPC(loadPC), .ALUCtrl(ALUCtrl), .MemRead(MemRead), .MemWrite(MemWrite),
    .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  assign ctrl_vec = {PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, ALUCtrl, MemRead, MemWrite};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected controls for a given pipeline phase (0=IF .. 4=WB), instruction and Zero.
  function automatic logic [11:0] exp_ctrl(input int st, input logic [31:0] ins, input logic z);
    logic [6:0] opc;
    logic [2:0] f3;
    logic       f7, r, i, lw, sw, bq;
    logic [3:0] alu;
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[30];
    r   = (opc == 7'h33);
    i   = (opc == 7'h13);
    lw  = (opc == 7'h03);
    sw  = (opc == 7'h23);
    bq  = (opc == 7'h63);
    alu = 4'b0010;
    if (r || i) begin
      case (f3)
        3'd0: alu = (r && f7) ? 4'b0110 : 4'b0010;
        3'd1: alu = 4'b1001;
        3'd2: alu = 4'b0111;
        3'd4: alu = 4'b1101;
        3'd5: alu = f7 ? 4'b1010 : 4'b1000;
        3'd6: alu = 4'b0001;
        3'd7: alu = 4'b0000;
        default: alu = 4'b0010;
      endcase
    end else if (bq) begin
      alu = 4'b0110;
    end
    return {(st == 4) && bq && z, i || lw || sw, (st == 4) && (r || i || lw), lw,
            st == 4, alu, (st == 3) && lw, (st == 3) && sw};
  endfunction

  // Runs one instruction from IF; holds = cycles of mem_ready low in MEM,
  // zmode 0/1 = fixed Zero, 2 = random per cycle; abort_at = cycle index to reset in.
  task automatic run_instr(input logic [31:0] ins, input int holds, input int zmode,
                           input int abort_at);
    int   st_q[$];
    logic is_mem;
    logic z;
    int   mj;
    is_mem = (ins[6:0] == 7'h03) || (ins[6:0] == 7'h23);
    st_q = '{0, 1, 2};
    for (int j = 0; j <= holds; j++)
      if (is_mem || j == 0) st_q.push_back(3);
    st_q.push_back(4);
    instr = ins;
    mj = 0;
    foreach (st_q[c]) begin
      z = (zmode == 2) ? 1'($urandom % 2) : (zmode == 1);
      Zero = z;
      if (st_q[c] == 3) begin
        mem_ready = is_mem ? (mj == holds) : (holds == 0);
        mj++;
      end else begin
        mem_ready = 1'($urandom % 2);
      end
      #1;
      chk("state", 64'(state), 64'(st_q[c]));
      chk("ctrl", 64'(ctrl_vec), 64'(exp_ctrl(st_q[c], ins, z)));
      chk("retired", 64'(retired), 64'(exp_ret));
      if (c == abort_at) begin
        #1 rst = 1'b1;
        #1;
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_ctrl", 64'(ctrl_vec), 64'(exp_ctrl(0, ins, z)));
        chk("rst_retired", 64'(retired), 64'd0);
        exp_ret = 0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (st_q[c] == 4) exp_ret = (exp_ret + 1) % (1 << CW);
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  op;
    int          k;
    w = $urandom;
    k = $urandom_range(0, 5);
    case (k)
      0: op = 7'h33;
      1: op = 7'h13;
      2: op = 7'h03;
      3: op = 7'h23;
      4: op = 7'h63;
      default: begin
        op = 7'($urandom);
        while (op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h23 || op == 7'h63)
          op = 7'($urandom);
      end
    endcase
    w[6:0] = op;
    while (w[14:12] == 3'd3) w[14:12] = 3'($urandom);
    return w;
  endfunction

  initial begin
    rst = 1'b1;
    instr = '0;
    Zero = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_state", 64'(state), 64'd0);
    chk("reset_retired", 64'(retired), 64'd0);
    chk("reset_ctrl", 64'(ctrl_vec), 64'(exp_ctrl(0, 32'h0, 1'b0)));
    rst = 1'b0;

    run_instr(32'h002081B3, 0, 0, -1);   // add x3,x1,x2
    chk("add_retired", 64'(retired), 64'd1);
    run_instr(32'h0080A283, 3, 2, -1);   // lw x5,8(x1), three wait cycles
    run_instr(32'h0020A223, 2, 2, -1);   // sw x2,4(x1)
    run_instr(32'hFE208CE3, 0, 1, -1);   // beq taken
    run_instr(32'hFE208CE3, 0, 0, -1);   // beq not taken
    run_instr(32'h0000007F, 2, 2, -1);   // NOP opcode, mem_ready low in MEM
    run_instr(32'h4020D193, 0, 2, -1);   // srai
    run_instr(32'h40208033, 0, 2, -1);   // sub
    run_instr(32'h40008013, 0, 2, -1);   // addi with funct7 bit set: still ADD
    run_instr(32'h002081B3, 0, 2, 2);    // reset in EX
    run_instr(32'h0080A283, 3, 2, 4);    // reset during MEM hold

    for (int n = 0; n < 16; n++) run_instr(32'h0000007F, 0, 2, -1);
    chk("wrap", 64'(retired), 64'd0);

    for (int n = 0; n < 60; n++) run_instr(rand_instr(), $urandom_range(0, 3), 2, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Parameter: CNT_WIDTH, default 32, width of the retired-instruction counter.
REQ-002 One clock, clk; reset rst is asynchronous, active-high.
REQ-003 clk  input  1  rising-edge clock shared with the datapath.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 instr  input  32  current instruction word, stable for a whole instruction.
REQ-006 Zero  input  1  ALU zero flag from the datapath.
REQ-007 mem_ready  input  1  data memory completion for the current access.
REQ-008 PCSrc, ALUSrc, RegWrite, MemToReg, loadPC  output  1 each  datapath controls.
REQ-009 ALUCtrl  output  4  ALU operation select.
REQ-010 MemRead, MemWrite  output  1 each  data memory strobes.
REQ-011 state  output  3  current FSM state, for debug.
REQ-012 retired  output  CNT_WIDTH  count of completed instructions.

Function
REQ-013 States and encodings shall be IF=0, ID=1, EX=2, MEM=3, WB=4; codes 5-7 are illegal and shall go to IF on the next edge.
REQ-014 Transitions shall be IF->ID->EX->MEM->WB->IF, one clock each, except the MEM hold in REQ-015.
REQ-015 MEM shall hold while (lw or sw) and mem_ready=0; for other opcodes, MEM shall exit after one cycle regardless of mem_ready.
REQ-016 Opcode decode from instr[6:0]:
- 0110011 R-type.
- 0010011 I-ALU.
- 0000011 lw.
- 0100011 sw.
- 1100011 beq.
- Any other opcode shall be a NOP, which still advances the PC.
REQ-017 ALUCtrl encoding: AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, SRL=1000, SLL=1001, SRA=1010, XOR=1101.
REQ-018 ALUCtrl for R-type and I-ALU shall come from funct3/funct7[5]:
- 000: ADD, or SUB if R-type with funct7[5]=1.
- 001: SLL.
- 010: SLT.
- 100: XOR.
- 101: SRL, or SRA if funct7[5]=1.
- 110: OR.
- 111: AND.
- addi shall ignore funct7.
REQ-019 ALUCtrl shall be ADD for lw, sw and NOP, and SUB for beq.
REQ-020 ALUSrc and MemToReg shall be level outputs, decoded combinationally in every state:
- ALUSrc=1 for I-ALU, lw and sw.
- MemToReg=1 for lw only.
REQ-021 MemRead=1 only in MEM for lw; MemWrite=1 only in MEM for sw; both shall stay high through any mem_ready hold.
REQ-022 RegWrite=1 only in WB for R-type, I-ALU and lw.
REQ-023 loadPC=1 only in WB, for every opcode including NOP.
REQ-024 PCSrc=1 only in WB when the opcode is beq and Zero=1.
REQ-025 retired shall increment by 1 on each clock edge leaving WB, and shall wrap from all-ones to 0.
REQ-026 Only state and retired shall be registered; all control outputs shall be combinational from state and instr, with no glitch requirement.

Reset
REQ-027 While rst=1, asynchronously: state=IF, retired=0, and RegWrite, loadPC, PCSrc, MemRead and MemWrite shall be 0.
REQ-028 Reset asserted mid-instruction, including during a MEM hold, shall abort that instruction with no write and no count.
REQ-029 After rst deasserts, the first edge shall move IF->ID.

Verification
REQ-030 add x3,x1,x2 (0x002081B3) from reset, mem_ready=1:
- States 0,1,2,3,4 then 0.
- ALUCtrl=0010.
- RegWrite=1 and loadPC=1 only in cycle 5.
- retired=1 after.
REQ-031 lw x5,8(x1) with mem_ready low for 3 MEM cycles:
- MEM lasts 4 cycles with MemRead=1 throughout.
- ALUSrc=1, MemToReg=1.
- RegWrite is asserted in WB.
REQ-032 sw x2,4(x1):
- MemWrite=1 only in MEM.
- RegWrite=0 in all states.
- loadPC=1 in WB.
REQ-033 beq x1,x2,-8:
- With Zero=1: PCSrc=1 and loadPC=1 in WB, ALUCtrl=0110.
- With Zero=0: PCSrc=0 in WB.
REQ-034 Opcode 0x7F (NOP): no RegWrite, MemRead or MemWrite; loadPC=1, PCSrc=0; retired increments.
REQ-035 rst pulse asserted in EX between edges:
- Outputs clear immediately and retired=0.
- Next instruction starts in IF.
- Also cover retired wrap with CNT_WIDTH=4: after 16 instructions, retired=0.
